// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared CPU package for the hazard controller.
// Holds the forwarding-select encodings, the multiply/divide and halt state
// enums, and a register-match helper that never matches register 0.
package pipeline_hazard_controller_pkg;

  localparam int unsigned REG_W = 5;

  // Execute-stage operand source select.
  typedef enum logic [1:0] {
    FWD_REGFILE   = 2'b00,
    FWD_WRITEBACK = 2'b01,
    FWD_MEMORY    = 2'b10
  } fwd_sel_e;

  // Multiply/divide unit occupancy.
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } multdiv_state_e;

  // Halt sequencing: let memory and writeback drain, then freeze.
  typedef enum logic [1:0] {
    HALT_RUN    = 2'b00,
    HALT_DRAIN  = 2'b01,
    HALT_HALTED = 2'b10
  } halt_state_e;

  // True when an enabled, nonzero destination equals the source register.
  function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src,
                                     input logic             wr_en);
    return wr_en && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_multdiv_busy_counter.sv
// Multiply/divide busy counter: busy for exactly MULT_CYCLES or DIV_CYCLES
// cycles after the start edge; a new start while busy restarts the count.
module multdiv_busy_counter
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  multdiv_state_e   r_state;
  multdiv_state_e   w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_load;

  assign w_load = i_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // State and count registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: load on start (also while busy), count down, leave at 1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      MD_IDLE: begin
        if (i_start) begin
          w_state_nxt = MD_BUSY;
          w_cnt_nxt   = w_load;
        end else begin
          w_state_nxt = MD_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      MD_BUSY: begin
        if (i_start) begin
          w_state_nxt = MD_BUSY;
          w_cnt_nxt   = w_load;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = MD_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = MD_BUSY;
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = MD_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_busy = (r_state == MD_BUSY);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use, branch-operand and HI/LO stalls,
// halt drain sequencing and operand forwarding selects.
// Optional feature macro: HAZARD_FORWARDING_EN. When undefined, forwarding
// selects are tied to 0 and any read-after-write on a decode source stalls.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs_decode,
  input  logic [REG_W-1:0] Rt_decode,
  input  logic [REG_W-1:0] Rs_execute,
  input  logic [REG_W-1:0] Rt_execute,
  input  logic [REG_W-1:0] write_register_execute,
  input  logic [REG_W-1:0] write_register_memory,
  input  logic [REG_W-1:0] write_register_writeback,
  input  logic             register_write_execute,
  input  logic             register_write_memory,
  input  logic             register_write_writeback,
  input  logic             memory_to_register_execute,
  input  logic             memory_to_register_memory,
  input  logic             branch_decode,
  input  logic             using_HI_LO_decode,
  input  logic             multdiv_start_execute,
  input  logic             multdiv_is_div_execute,
  input  logic             HALT_execute,
  output logic             stall_fetch,
  output logic             stall_decode,
  output logic             clear_execute,
  output logic [1:0]       forward_A_execute,
  output logic [1:0]       forward_B_execute,
  output logic             forward_A_decode,
  output logic             forward_B_decode,
  output logic             multdiv_busy,
  output logic             halted
);

  halt_state_e r_halt_state;
  halt_state_e w_halt_nxt;
  logic        r_drain_cnt;
  logic        w_drain_nxt;

  logic        w_busy;
  logic        w_load_use;
  logic        w_branch_hazard;
  logic        w_hilo_hazard;
  logic        w_halt_stall;
  logic        w_raw_stall;
  logic        w_stall;
  fwd_sel_e    w_fwd_a;
  fwd_sel_e    w_fwd_b;
  logic        w_fwd_a_dec;
  logic        w_fwd_b_dec;

  multdiv_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_multdiv_busy_counter (
    .clk      (clk),
    .reset    (reset),
    .i_start  (multdiv_start_execute),
    .i_is_div (multdiv_is_div_execute),
    .o_busy   (w_busy)
  );

  // Halt state and drain-cycle registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_halt_state <= HALT_RUN;
      r_drain_cnt  <= 1'b0;
    end else begin
      r_halt_state <= w_halt_nxt;
      r_drain_cnt  <= w_drain_nxt;
    end
  end

  // Halt next state: two drain cycles (memory, writeback), then terminal.
  always_comb begin
    w_halt_nxt  = r_halt_state;
    w_drain_nxt = r_drain_cnt;
    case (r_halt_state)
      HALT_RUN: begin
        if (HALT_execute) begin
          w_halt_nxt  = HALT_DRAIN;
          w_drain_nxt = 1'b0;
        end else begin
          w_halt_nxt  = HALT_RUN;
          w_drain_nxt = 1'b0;
        end
      end
      HALT_DRAIN: begin
        if (r_drain_cnt) begin
          w_halt_nxt  = HALT_HALTED;
          w_drain_nxt = 1'b0;
        end else begin
          w_halt_nxt  = HALT_DRAIN;
          w_drain_nxt = 1'b1;
        end
      end
      HALT_HALTED: begin
        w_halt_nxt  = HALT_HALTED;
        w_drain_nxt = 1'b0;
      end
      default: begin
        w_halt_nxt  = HALT_RUN;
        w_drain_nxt = 1'b0;
      end
    endcase
  end

  // Stall sources common to both build variants.
  always_comb begin
    w_load_use = memory_to_register_execute &&
                 (reg_match(write_register_execute, Rs_decode, 1'b1) ||
                  reg_match(write_register_execute, Rt_decode, 1'b1));
    w_branch_hazard = branch_decode &&
                 (reg_match(write_register_execute, Rs_decode, register_write_execute) ||
                  reg_match(write_register_execute, Rt_decode, register_write_execute) ||
                  reg_match(write_register_memory, Rs_decode, memory_to_register_memory) ||
                  reg_match(write_register_memory, Rt_decode, memory_to_register_memory));
    w_hilo_hazard = using_HI_LO_decode && w_busy;
    w_halt_stall  = (r_halt_state != HALT_RUN) || HALT_execute;
  end

`ifdef HAZARD_FORWARDING_EN
  // Forwarding selects; the memory stage holds the younger value and wins.
  always_comb begin
    w_fwd_a = FWD_REGFILE;
    w_fwd_b = FWD_REGFILE;
    if (reg_match(write_register_memory, Rs_execute, register_write_memory)) begin
      w_fwd_a = FWD_MEMORY;
    end else if (reg_match(write_register_writeback, Rs_execute, register_write_writeback)) begin
      w_fwd_a = FWD_WRITEBACK;
    end else begin
      w_fwd_a = FWD_REGFILE;
    end
    if (reg_match(write_register_memory, Rt_execute, register_write_memory)) begin
      w_fwd_b = FWD_MEMORY;
    end else if (reg_match(write_register_writeback, Rt_execute, register_write_writeback)) begin
      w_fwd_b = FWD_WRITEBACK;
    end else begin
      w_fwd_b = FWD_REGFILE;
    end
    w_fwd_a_dec = reg_match(write_register_memory, Rs_decode, register_write_memory);
    w_fwd_b_dec = reg_match(write_register_memory, Rt_decode, register_write_memory);
    w_raw_stall = 1'b0;
  end
`else
  logic w_unused_exec_srcs;
  assign w_unused_exec_srcs = ^{Rs_execute, Rt_execute};

  // No bypass paths: any in-flight write to a decode source stalls.
  always_comb begin
    w_fwd_a     = FWD_REGFILE;
    w_fwd_b     = FWD_REGFILE;
    w_fwd_a_dec = 1'b0;
    w_fwd_b_dec = 1'b0;
    w_raw_stall = reg_match(write_register_execute,   Rs_decode, register_write_execute)   ||
                  reg_match(write_register_execute,   Rt_decode, register_write_execute)   ||
                  reg_match(write_register_memory,    Rs_decode, register_write_memory)    ||
                  reg_match(write_register_memory,    Rt_decode, register_write_memory)    ||
                  reg_match(write_register_writeback, Rs_decode, register_write_writeback) ||
                  reg_match(write_register_writeback, Rt_decode, register_write_writeback);
  end
`endif

  assign w_stall = w_halt_stall | w_load_use | w_branch_hazard | w_hilo_hazard | w_raw_stall;

  assign stall_fetch       = w_stall;
  assign stall_decode      = w_stall;
  assign clear_execute     = w_stall;
  assign forward_A_execute = w_fwd_a;
  assign forward_B_execute = w_fwd_b;
  assign forward_A_decode  = w_fwd_a_dec;
  assign forward_B_decode  = w_fwd_b_dec;
  assign multdiv_busy      = w_busy;
  assign halted            = (r_halt_state == HALT_HALTED);

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller. Expected outputs are
// queued when a stimulus cycle is driven and popped when outputs are sampled.
// Expectations follow HAZARD_FORWARDING_EN when it is defined for the build.
module tb_pipeline_hazard_controller;

  localparam int unsigned MC = 4;
  localparam int unsigned DC = 32;

`ifdef HAZARD_FORWARDING_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs_decode, Rt_decode, Rs_execute, Rt_execute;
  logic [4:0] write_register_execute, write_register_memory, write_register_writeback;
  logic       register_write_execute, register_write_memory, register_write_writeback;
  logic       memory_to_register_execute, memory_to_register_memory;
  logic       branch_decode, using_HI_LO_decode, multdiv_start_execute;
  logic       multdiv_is_div_execute, HALT_execute;
  logic       stall_fetch, stall_decode, clear_execute;
  logic [1:0] forward_A_execute, forward_B_execute;
  logic       forward_A_decode, forward_B_decode, multdiv_busy, halted;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .Rs_decode                  (Rs_decode),
    .Rt_decode                  (Rt_decode),
    .Rs_execute                 (Rs_execute),
    .Rt_execute                 (Rt_execute),
    .write_register_execute     (write_register_execute),
    .write_register_memory      (write_register_memory),
    .write_register_writeback   (write_register_writeback),
    .register_write_execute     (register_write_execute),
    .register_write_memory      (register_write_memory),
    .register_write_writeback   (register_write_writeback),
    .memory_to_register_execute (memory_to_register_execute),
    .memory_to_register_memory  (memory_to_register_memory),
    .branch_decode              (branch_decode),
    .using_HI_LO_decode         (using_HI_LO_decode),
    .multdiv_start_execute      (multdiv_start_execute),
    .multdiv_is_div_execute     (multdiv_is_div_execute),
    .HALT_execute               (HALT_execute),
    .stall_fetch                (stall_fetch),
    .stall_decode               (stall_decode),
    .clear_execute              (clear_execute),
    .forward_A_execute          (forward_A_execute),
    .forward_B_execute          (forward_B_execute),
    .forward_A_decode           (forward_A_decode),
    .forward_B_decode           (forward_B_decode),
    .multdiv_busy               (multdiv_busy),
    .halted                     (halted)
  );

  typedef struct {
    string      tag;
    logic       stall;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       fad;
    logic       fbd;
    logic       busy;
    logic       hlt;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle_inputs();
    Rs_decode = 5'd0; Rt_decode = 5'd0; Rs_execute = 5'd0; Rt_execute = 5'd0;
    write_register_execute = 5'd0; write_register_memory = 5'd0; write_register_writeback = 5'd0;
    register_write_execute = 1'b0; register_write_memory = 1'b0; register_write_writeback = 1'b0;
    memory_to_register_execute = 1'b0; memory_to_register_memory = 1'b0;
    branch_decode = 1'b0; using_HI_LO_decode = 1'b0; multdiv_start_execute = 1'b0;
    multdiv_is_div_execute = 1'b0; HALT_execute = 1'b0;
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, ".stall_fetch"},   {7'd0, stall_fetch},      {7'd0, e.stall});
      chk({e.tag, ".stall_decode"},  {7'd0, stall_decode},     {7'd0, e.stall});
      chk({e.tag, ".clear_execute"}, {7'd0, clear_execute},    {7'd0, e.stall});
      chk({e.tag, ".fwd_A_ex"},      {6'd0, forward_A_execute}, {6'd0, e.fa});
      chk({e.tag, ".fwd_B_ex"},      {6'd0, forward_B_execute}, {6'd0, e.fb});
      chk({e.tag, ".fwd_A_dec"},     {7'd0, forward_A_decode}, {7'd0, e.fad});
      chk({e.tag, ".fwd_B_dec"},     {7'd0, forward_B_decode}, {7'd0, e.fbd});
      chk({e.tag, ".busy"},          {7'd0, multdiv_busy},     {7'd0, e.busy});
      chk({e.tag, ".halted"},        {7'd0, halted},           {7'd0, e.hlt});
    end
  endtask

  // Inputs for this cycle are already driven: queue the expectation, let the
  // combinational outputs settle, then compare.
  task automatic step(input string tag, input logic stall, input logic [1:0] fa,
                      input logic [1:0] fb, input logic fad, input logic fbd,
                      input logic busy, input logic hlt);
    exp_t e;
    e.tag = tag; e.stall = stall; e.fa = fa; e.fb = fb;
    e.fad = fad; e.fbd = fbd; e.busy = busy; e.hlt = hlt;
    sb_q.push_back(e);
    #1;
    pop_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    step("reset", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // lw $2 in execute, dependent in decode
    @(negedge clk); idle_inputs();
    memory_to_register_execute = 1'b1; register_write_execute = 1'b1;
    write_register_execute = 5'd2; Rs_decode = 5'd2;
    step("load_use", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // the load has moved to memory; the consumer is not a branch
    @(negedge clk); idle_inputs();
    memory_to_register_memory = 1'b1; register_write_memory = 1'b1;
    write_register_memory = 5'd2; Rs_decode = 5'd2;
    step("load_in_mem", !FWD_ON, 2'b00, 2'b00, FWD_ON, 1'b0, 1'b0, 1'b0);

    // load to $0 never stalls
    @(negedge clk); idle_inputs();
    memory_to_register_execute = 1'b1; register_write_execute = 1'b1;
    branch_decode = 1'b1;
    step("load_r0", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // memory and writeback both write $5: memory wins
    @(negedge clk); idle_inputs();
    register_write_memory = 1'b1; write_register_memory = 5'd5;
    register_write_writeback = 1'b1; write_register_writeback = 5'd5;
    Rs_execute = 5'd5; Rs_decode = 5'd5;
    step("fwd_mem_prio", !FWD_ON, FWD_ON ? 2'b10 : 2'b00, 2'b00, FWD_ON, 1'b0, 1'b0, 1'b0);

    // writeback only, both execute operands
    @(negedge clk); idle_inputs();
    register_write_writeback = 1'b1; write_register_writeback = 5'd9;
    Rs_execute = 5'd9; Rt_execute = 5'd9;
    step("fwd_wb", 1'b0, FWD_ON ? 2'b01 : 2'b00, FWD_ON ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // matching destination without its write enable
    @(negedge clk); idle_inputs();
    write_register_memory = 5'd6; Rs_execute = 5'd6; Rt_decode = 5'd6;
    step("fwd_no_we", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // writing $0 is never forwarded
    @(negedge clk); idle_inputs();
    register_write_memory = 1'b1; register_write_writeback = 1'b1;
    step("fwd_r0", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // branch needs an ALU result still in execute
    @(negedge clk); idle_inputs();
    branch_decode = 1'b1; register_write_execute = 1'b1;
    write_register_execute = 5'd3; Rt_decode = 5'd3;
    step("branch_ex", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // branch needs a load result in memory
    @(negedge clk); idle_inputs();
    branch_decode = 1'b1; memory_to_register_memory = 1'b1; register_write_memory = 1'b1;
    write_register_memory = 5'd4; Rs_decode = 5'd4;
    step("branch_mem_load", 1'b1, 2'b00, 2'b00, FWD_ON, 1'b0, 1'b0, 1'b0);

    // branch takes an ALU result from memory through the bypass
    @(negedge clk); idle_inputs();
    branch_decode = 1'b1; register_write_memory = 1'b1;
    write_register_memory = 5'd7; Rt_decode = 5'd7;
    step("branch_mem_alu", !FWD_ON, 2'b00, 2'b00, 1'b0, FWD_ON, 1'b0, 1'b0);

    // ALU producer in execute, non-branch consumer
    @(negedge clk); idle_inputs();
    register_write_execute = 1'b1; write_register_execute = 5'd8; Rs_decode = 5'd8;
    step("raw_ex", !FWD_ON, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // multiply: busy exactly MC cycles after the start edge
    @(negedge clk); idle_inputs();
    multdiv_start_execute = 1'b1;
    step("mul_start", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= int'(MC) + 1; k++) begin
      @(negedge clk); idle_inputs();
      step($sformatf("mul_c%0d", k), 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, k <= int'(MC), 1'b0);
    end

    // divide with mflo arriving in decode at cycle 10
    @(negedge clk); idle_inputs();
    multdiv_start_execute = 1'b1; multdiv_is_div_execute = 1'b1;
    step("div_start", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= int'(DC) + 1; k++) begin
      @(negedge clk); idle_inputs();
      using_HI_LO_decode = (k >= 10);
      step($sformatf("div_c%0d", k), (k >= 10) && (k <= int'(DC)), 2'b00, 2'b00,
           1'b0, 1'b0, k <= int'(DC), 1'b0);
    end

    // divide restarted by a multiply at cycle 3
    @(negedge clk); idle_inputs();
    multdiv_start_execute = 1'b1; multdiv_is_div_execute = 1'b1;
    step("rst_div_start", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= int'(MC) + 4; k++) begin
      @(negedge clk); idle_inputs();
      multdiv_start_execute = (k == 3);
      step($sformatf("restart_c%0d", k), 1'b0, 2'b00, 2'b00, 1'b0, 1'b0,
           k <= int'(MC) + 3, 1'b0);
    end

    // reset while the divide counter holds 7
    @(negedge clk); idle_inputs();
    multdiv_start_execute = 1'b1; multdiv_is_div_execute = 1'b1;
    step("abort_div_start", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= int'(DC) - 6; k++) begin
      @(negedge clk); idle_inputs();
      step($sformatf("abort_c%0d", k), 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    using_HI_LO_decode = 1'b1;
    #1 reset = 1'b0;
    step("abort_reset", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b1;
    step("abort_after", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // halt pulse: immediate stall, two drain cycles, then halted forever
    @(negedge clk); idle_inputs();
    HALT_execute = 1'b1;
    step("halt_seen", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); idle_inputs();
      step($sformatf("halt_c%0d", k), 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, k >= 3);
    end
    @(negedge clk); reset = 1'b0;
    step("halt_reset", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b1;
    step("halt_after", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 4: execute-stage busy cycles after a multiply starts.
REQ-002 SHALL have parameter DIV_CYCLES, default 32: execute-stage busy cycles after a divide starts.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports Rs_decode, Rt_decode, Rs_execute, Rt_execute  input  5 each  source register numbers.
REQ-006 SHALL have ports write_register_execute, write_register_memory, write_register_writeback  input  5 each  destination register numbers.
REQ-007 SHALL have ports register_write_execute, register_write_memory, register_write_writeback, memory_to_register_execute, memory_to_register_memory  input  1 each  stage control.
REQ-008 SHALL have ports branch_decode, using_HI_LO_decode, multdiv_start_execute, multdiv_is_div_execute, HALT_execute  input  1 each.
REQ-009 SHALL have ports stall_fetch, stall_decode, clear_execute  output  1 each; clear_execute drives the decode/execute register clear.
REQ-010 SHALL have ports forward_A_execute, forward_B_execute  output  2 each  (00 register file, 01 writeback result, 10 memory result).
REQ-011 SHALL have ports forward_A_decode, forward_B_decode  output  1 each  (1 = memory-stage result into branch comparator).
REQ-012 SHALL have ports multdiv_busy, halted  output  1 each.

Function
REQ-013 SHALL assert load_use when memory_to_register_execute && write_register_execute != 0 && write_register_execute is Rs_decode or Rt_decode.
REQ-014 SHALL assert branch_hazard when branch_decode and (register_write_execute with write_register_execute != 0 matching Rs_decode/Rt_decode, or memory_to_register_memory with write_register_memory != 0 matching).
REQ-015 SHALL assert hilo_hazard when using_HI_LO_decode && multdiv_busy.
REQ-016 SHALL, when any of load_use, branch_hazard, hilo_hazard, or halt state holds, drive stall_fetch=1, stall_decode=1 and clear_execute=1 in the same cycle (combinational).
REQ-017 SHALL have a multdiv counter: multdiv_start_execute in IDLE loads DIV_CYCLES if multdiv_is_div_execute else MULT_CYCLES, state BUSY; decrement each cycle; at count 1 return IDLE; multdiv_busy=1 exactly N cycles after the start edge.
REQ-018 SHALL restart the counter with the new latency if multdiv_start_execute arrives while BUSY.
REQ-019 SHALL have halt states RUN, DRAIN, HALTED: HALT_execute in RUN -> DRAIN; DRAIN lasts 2 cycles (memory, writeback drain) -> HALTED; HALTED is terminal until reset; halted=1 only in HALTED.
REQ-020 SHALL hold stalls and clear_execute at 1 in the cycle HALT_execute is seen and in DRAIN and HALTED; halt dominates all other conditions.
REQ-021 SHALL never forward or detect hazards on register 0.
REQ-022 SHALL give memory-stage forwarding priority over writeback when both match.

Reset
REQ-023 SHALL, on reset low, asynchronously set counter to 0, multdiv state IDLE, halt state RUN; outputs then follow combinational hazard logic only; reset mid-busy or mid-drain abandons the operation.

Configuration
REQ-024 SHALL, with HAZARD_FORWARDING_EN defined, drive forward outputs per REQ-010/011/022.
REQ-025 SHALL, without HAZARD_FORWARDING_EN, tie all forward outputs to 0 and additionally stall (per REQ-016) whenever Rs_decode/Rt_decode matches any nonzero destination with its register_write set in execute, memory or writeback.

Structure
REQ-026 SHALL place forwarding-select encodings and the halt/multdiv state enums in the shared CPU package.
REQ-027 SHALL implement the multdiv counter as sub-module multdiv_busy_counter; the rest stays flat.

Verification
REQ-028 SHALL verify: lw $2 in execute, Rs_decode=2 -> stall_fetch=stall_decode=clear_execute=1 for one cycle.
REQ-029 SHALL verify: write_register_memory=5 and write_register_writeback=5 both writing, Rs_execute=5 -> forward_A_execute=10; with macro off -> 00 plus stall.
REQ-030 SHALL verify: div start -> multdiv_busy high 32 cycles; mflo in decode at cycle 10 stalls until busy falls.
REQ-031 SHALL verify: HALT_execute pulse -> stalls immediately, halted=1 after 2 cycles, persists until reset.
REQ-032 SHALL verify: reset low during BUSY count 7 -> multdiv_busy=0 immediately, no residual stall.
REQ-033 SHALL verify: write_register_execute=0 load with Rs_decode=0 -> no stall.
